// File: rtl/keypad_scanner_if.sv
// Keypad scanner pin bundle: matrix rows/columns plus the decoded key outputs.
// Master is the scanner; slave is the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] kbd;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;

  modport master (
    output row_n, kbd, key_code, key_valid, key_strobe,
    input  col_n
  );

  modport slave (
    input  row_n, kbd, key_code, key_valid, key_strobe,
    output col_n
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 keypad matrix scanner with scan-level debounce; KEYPAD_REPEAT_EN adds auto-repeat strobes.
// Outputs update one cycle after the DEB_SCANS-th agreeing scan; no backpressure (level outputs + pulse).
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEB_SCANS    = 3,
  parameter int REPEAT_SCANS = 8
) (
  input  logic             clk,
  input  logic             resetn,
  keypad_scanner_if.master kp
);
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_e;

  if (SCAN_DIV < 4 || SCAN_DIV > 255) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be 4..255");
  end
  if (DEB_SCANS < 1 || DEB_SCANS > 15) begin : g_bad_deb_scans
    $error("keypad_scanner: DEB_SCANS must be 1..15");
  end
  if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_repeat_scans
    $error("keypad_scanner: REPEAT_SCANS must be 1..255");
  end

  function automatic logic [3:0] key_at(input row_e r, input int c);
    if (r == ROW3) begin
      case (c)
        0:       return 4'd10;
        1:       return 4'd0;
        default: return 4'd11;
      endcase
    end
    return 4'(int'(r) * 3 + c + 1);
  endfunction

  function automatic logic [9:0] onehot(input logic [3:0] k);
    return (k < 4'd10) ? (10'd1 << k) : 10'd0;
  endfunction

  logic [2:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [7:0] div_q, div_d;
  row_e       row_q, row_d;
  logic [1:0] hits_q, hits_d, hits_nx;
  logic [3:0] hit_key_q, hit_key_d, key_nx;
  logic [3:0] cand_q, cand_d, deb_q, deb_d;
  logic [3:0] key_code_q, key_code_d;
  logic [9:0] kbd_q, kbd_d;
  logic       valid_q, valid_d, strobe_q, strobe_d;
  logic       slot_end, scan_end, accept;
  logic [3:0] scan_res;
`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rpt_q, rpt_d;
`endif

  always_comb begin
    col_s1_d   = kp.col_n;
    col_s2_d   = col_s1_q;
    div_d      = div_q;
    row_d      = row_q;
    hits_d     = hits_q;
    hit_key_d  = hit_key_q;
    cand_d     = cand_q;
    deb_d      = deb_q;
    key_code_d = key_code_q;
    kbd_d      = kbd_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    hits_nx    = hits_q;
    key_nx     = hit_key_q;
    scan_res   = KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
    rpt_d      = rpt_q;
`endif

    slot_end = (div_q == 8'(SCAN_DIV - 1));
    scan_end = slot_end && (row_q == ROW3);
    accept   = (deb_q == 4'(DEB_SCANS)) && (cand_q != key_code_q);

    // hits saturates at 2: anything beyond one closed switch is ambiguous
    for (int c = 0; c < 3; c++) begin
      if (!col_s2_q[c]) begin
        if (hits_nx == 2'd0) key_nx = key_at(row_q, c);
        if (hits_nx != 2'd2) hits_nx = hits_nx + 2'd1;
      end
    end

    if (slot_end) begin
      div_d     = '0;
      row_d     = row_e'(row_q + 2'd1);
      hits_d    = hits_nx;
      hit_key_d = key_nx;
    end else begin
      div_d = div_q + 8'd1;
    end

    if (scan_end) begin
      hits_d    = '0;
      hit_key_d = KEY_NONE;
      scan_res  = (hits_nx == 2'd1) ? key_nx : KEY_NONE;
      if (scan_res == cand_q) begin
        if (deb_q != 4'(DEB_SCANS)) deb_d = deb_q + 4'd1;
      end else begin
        cand_d = scan_res;
        deb_d  = 4'd1;
      end
    end

    if (accept) begin
      key_code_d = cand_q;
      kbd_d      = onehot(cand_q);
      valid_d    = (cand_q != KEY_NONE);
      strobe_d   = (cand_q != KEY_NONE);
    end

`ifdef KEYPAD_REPEAT_EN
    if (accept) begin
      rpt_d = '0;
    end else if (scan_end && valid_q) begin
      if (rpt_q == 8'(REPEAT_SCANS - 1)) begin
        rpt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        rpt_d = rpt_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_s1_q   <= 3'b111;
      col_s2_q   <= 3'b111;
      div_q      <= '0;
      row_q      <= ROW0;
      hits_q     <= '0;
      hit_key_q  <= KEY_NONE;
      cand_q     <= KEY_NONE;
      deb_q      <= '0;
      key_code_q <= KEY_NONE;
      kbd_q      <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q      <= '0;
`endif
    end else begin
      col_s1_q   <= col_s1_d;
      col_s2_q   <= col_s2_d;
      div_q      <= div_d;
      row_q      <= row_d;
      hits_q     <= hits_d;
      hit_key_q  <= hit_key_d;
      cand_q     <= cand_d;
      deb_q      <= deb_d;
      key_code_q <= key_code_d;
      kbd_q      <= kbd_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q      <= rpt_d;
`endif
    end
  end

  assign kp.row_n      = ~(4'b0001 << row_q);
  assign kp.kbd        = kbd_q;
  assign kp.key_code   = key_code_q;
  assign kp.key_valid  = valid_q;
  assign kp.key_strobe = strobe_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix keypad model drives the columns, and a
// scan-level reference (last-N-results window) predicts outputs and strobe counts.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REPEAT   = 8;
  localparam int SCAN_CYC = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_ON = 1;
`else
  localparam int RPT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] held = '0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEB_SCANS    (DEB),
    .REPEAT_SCANS (REPEAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .kp     (kp)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a closed switch pulls its column low while its row is driven low.
  function automatic logic [2:0] cols_of(input logic [3:0] rn, input logic [11:0] s);
    logic [2:0] c = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++)
        if (!rn[r] && s[r*3+k]) c[k] = 1'b0;
    return c;
  endfunction

  assign kp.col_n = cols_of(kp.row_n, held);

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int strobes_seen = 0;
  int first_strobe = -1;
  int last_fall = -1;
  bit prev_valid = 1'b0;

  int m_acc = 15;
  int m_hist[$];
  int m_strobes = 0;
  int m_scan = 0;
  int m_acc_scan = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int code_of_pos(input int p);
    if (p < 9) return p + 1;
    if (p == 9) return 10;
    if (p == 10) return 0;
    return 11;
  endfunction

  function automatic logic [11:0] mask_of(input int code);
    logic [11:0] m = '0;
    for (int p = 0; p < 12; p++)
      if (code_of_pos(p) == code) m[p] = 1'b1;
    return m;
  endfunction

  function automatic int scan_result(input logic [11:0] s);
    if ($countones(s) != 1) return 15;
    for (int p = 0; p < 12; p++)
      if (s[p]) return code_of_pos(p);
    return 15;
  endfunction

  // Accept r once the last DEB scans all read r and it differs from what is held.
  task automatic model_scan(input logic [11:0] s);
    int  r;
    bit  same;
    r = scan_result(s);
    if (RPT_ON != 0 && m_acc != 15 && m_scan > m_acc_scan && ((m_scan - m_acc_scan) % REPEAT) == 0)
      m_strobes++;
    m_hist.push_back(r);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      same = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != r) same = 1'b0;
      if (same && r != m_acc) begin
        m_acc      = r;
        m_acc_scan = m_scan;
        if (r != 15) m_strobes++;
      end
    end
    m_scan++;
  endtask

  task automatic tick();
    logic [3:0] exp_row;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_row = ~(4'b0001 << ((cyc % SCAN_CYC) / SCAN_DIV));
    check("row_n", int'(kp.row_n), int'(exp_row));
    if (kp.key_strobe) begin
      strobes_seen++;
      if (first_strobe < 0) first_strobe = cyc;
    end
    if (prev_valid && !kp.key_valid) last_fall = cyc;
    prev_valid = kp.key_valid;
  endtask

  task automatic do_scan(input logic [11:0] s);
    held = s;
    for (int c = 0; c < SCAN_CYC; c++) begin
      tick();
      if (c == 1) begin
        check("kbd", int'(kp.kbd), (m_acc < 10) ? (1 << m_acc) : 0);
        check("key_code", int'(kp.key_code), m_acc);
        check("key_valid", int'(kp.key_valid), (m_acc != 15) ? 1 : 0);
        check("strobe_count", strobes_seen, m_strobes);
      end
    end
    model_scan(s);
  endtask

  task automatic scans(input logic [11:0] s, input int n);
    for (int i = 0; i < n; i++) do_scan(s);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_strobe", int'(kp.key_strobe), 0);
    end
    check("rst_row_n", int'(kp.row_n), 14);
    check("rst_kbd", int'(kp.kbd), 0);
    check("rst_key_code", int'(kp.key_code), 15);
    check("rst_key_valid", int'(kp.key_valid), 0);
    resetn     = 1'b1;
    cyc        = 0;
    prev_valid = 1'b0;
    m_acc      = 15;
    m_hist.delete();
    m_scan     = 0;
    m_acc_scan = 0;
  endtask

  initial begin
    int s0;
    int t0;
    logic [11:0] m;

    do_reset();

    // Press 5 straight out of reset.
    first_strobe = -1;
    t0 = cyc;
    scans(mask_of(5), 5);
    check("press5_latency_in_48_64", int'(first_strobe - t0 >= 48 && first_strobe - t0 <= 64), 1);
    check("press5_kbd", int'(kp.kbd), 32);
    check("press5_code", int'(kp.key_code), 5);

    // Release 5: falls back to none without a strobe.
    s0 = strobes_seen;
    last_fall = -1;
    t0 = cyc;
    scans('0, 5);
    check("release5_latency_in_48_64", int'(last_fall - t0 >= 48 && last_fall - t0 <= 64), 1);
    check("release5_strobes", strobes_seen - s0, 0);

    // 1 and 2 together are ambiguous; dropping 2 leaves 1.
    s0 = strobes_seen;
    scans(mask_of(1) | mask_of(2), 5);
    check("dual_kbd", int'(kp.kbd), 0);
    check("dual_strobes", strobes_seen - s0, 0);
    scans(mask_of(1), 5);
    check("single1_kbd", int'(kp.kbd), 2);
    scans('0, 5);

    // Short bounce of 9 must not get through.
    s0 = strobes_seen;
    scans(mask_of(9), 2);
    scans('0, 5);
    check("bounce9_strobes", strobes_seen - s0, 0);
    check("bounce9_code", int'(kp.key_code), 15);

    // Long hold of #.
    s0 = strobes_seen;
    scans(mask_of(11), 20);
    check("hash_code", int'(kp.key_code), 11);
    check("hash_kbd", int'(kp.kbd), 0);
    scans('0, 5);
    check("hash_strobes", strobes_seen - s0, (RPT_ON != 0) ? 3 : 1);

    // Reset mid-scan with 7 held, then re-acceptance.
    scans(mask_of(7), 5);
    check("hold7_code", int'(kp.key_code), 7);
    for (int i = 0; i < int'($urandom_range(1, SCAN_CYC - 1)); i++) tick();
    do_reset();
    first_strobe = -1;
    t0 = cyc;
    scans(mask_of(7), 5);
    check("reacc7_latency_in_48_64", int'(first_strobe - t0 >= 48 && first_strobe - t0 <= 64), 1);
    check("reacc7_code", int'(kp.key_code), 7);

    // Random segments: single keys, nothing, or two keys at once.
    for (int seg = 0; seg < 40; seg++) begin
      int kind;
      int p1;
      int p2;
      kind = int'($urandom_range(0, 9));
      p1   = int'($urandom_range(0, 11));
      p2   = (p1 + int'($urandom_range(1, 11))) % 12;
      m    = '0;
      if (kind < 6) begin
        m[p1] = 1'b1;
      end else if (kind >= 8) begin
        m[p1] = 1'b1;
        m[p2] = 1'b1;
      end
      scans(m, int'($urandom_range(1, 5)));
    end
    scans('0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
